// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, constants and helpers for data_mem_responder.
// Revision    : 1.0
// ============================================================================
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WAIT_CYCLES_DEF = 2;
  localparam int CNT_W           = 4;
  localparam int N_LEGAL_SEL     = 8;

  // Byte, aligned halfword, full word and the empty pattern.
  localparam logic [3:0] LEGAL_SEL [N_LEGAL_SEL] = '{
    4'b0000, 4'b0001, 4'b0010, 4'b0100,
    4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic sel_is_legal(input logic [3:0] sel);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_LEGAL_SEL; i++) begin
      if (sel == LEGAL_SEL[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Request/response and debug-read bundle of the data memory.
// Revision    : 1.0
// ============================================================================
interface data_mem_responder_if #(
  parameter int ADDR_W = 10
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_sel;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [3:0]        dbg_addr;
  logic [31:0]       dbg_data;

  modport master (
    output req_valid, req_we, req_addr, req_sel, req_wdata, rsp_ready, dbg_addr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_sel, req_wdata, rsp_ready, dbg_addr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_data
  );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : 32-bit word storage, byte-lane write, sync read, comb debug read.
// Revision    : 1.0
// ============================================================================
module dmem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_dvid,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [3:0]        i_wr_sel,
  input  logic [31:0]       i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [31:0]       o_rd_data,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [31:0]       o_dbg_data
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_rd_data;

  // Storage is intentionally never reset.
  always_ff @(posedge clk_dvid) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_sel[b]) r_mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data  = r_rd_data;
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Single-outstanding data memory responder with fixed wait states.
//               Define DMEM_SEL_CHECK_EN to reject non-aligned lane patterns.
// Revision    : 1.0
// ============================================================================
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int ADDR_W      = 10
) (
  input  logic                clk_dvid,
  input  logic                reset,
  data_mem_responder_if.slave bus
);

  localparam logic [CNT_W-1:0] C_WAIT = CNT_W'(WAIT_CYCLES);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_accept;
  logic               w_enter_resp;

  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [3:0]         r_sel;
  logic [31:0]        r_wdata;
  logic               r_err;
  logic               r_rd_flag;

  logic               w_cur_we;
  logic [ADDR_W-1:0]  w_cur_addr;
  logic [3:0]         w_cur_sel;
  logic [31:0]        w_cur_wdata;
  logic               w_sel_bad;
  logic               w_wr_en;
  logic               w_rd_en;
  logic [31:0]        w_arr_rd;

  assign w_accept = bus.req_valid && (r_state == IDLE);

  // With zero wait states the commit happens on the accept edge itself,
  // before the request has been latched, so take the live inputs then.
  assign w_cur_we    = (r_state == IDLE) ? bus.req_we    : r_we;
  assign w_cur_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
  assign w_cur_sel   = (r_state == IDLE) ? bus.req_sel   : r_sel;
  assign w_cur_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;

`ifdef DMEM_SEL_CHECK_EN
  assign w_sel_bad = !sel_is_legal(w_cur_sel);
`else
  assign w_sel_bad = 1'b0;
`endif

  always_ff @(posedge clk_dvid) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (C_WAIT == '0) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
            w_cnt_nxt    = '0;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = C_WAIT;
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
          w_cnt_nxt    = '0;
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Reset must win over a commit landing on the same edge.
  assign w_wr_en = w_enter_resp && w_cur_we && !w_sel_bad && !reset;
  assign w_rd_en = w_enter_resp && !w_cur_we && !reset;

  always_ff @(posedge clk_dvid) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_sel     <= '0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_rd_flag <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= bus.req_we;
        r_addr  <= bus.req_addr;
        r_sel   <= bus.req_sel;
        r_wdata <= bus.req_wdata;
      end
      if (w_enter_resp) begin
        r_err     <= w_sel_bad;
        r_rd_flag <= !w_cur_we && !w_sel_bad;
      end else if ((r_state == RESP) && bus.rsp_ready) begin
        r_err     <= 1'b0;
        r_rd_flag <= 1'b0;
      end
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_dvid   (clk_dvid),
    .i_we       (w_wr_en),
    .i_wr_addr  (w_cur_addr),
    .i_wr_sel   (w_cur_sel),
    .i_wr_data  (w_cur_wdata),
    .i_rd_en    (w_rd_en),
    .i_rd_addr  (w_cur_addr),
    .o_rd_data  (w_arr_rd),
    .i_dbg_addr (ADDR_W'(bus.dbg_addr)),
    .o_dbg_data (bus.dbg_data)
  );

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_err   = r_err;
  assign bus.rsp_rdata = r_rd_flag ? (w_arr_rd & sel_to_mask(r_sel)) : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Vector-table and scoreboard bench for data_mem_responder.
// Revision    : 1.0
// ============================================================================
module tb_data_mem_responder;

  localparam int W = 2;
`ifdef DMEM_SEL_CHECK_EN
  localparam bit SEL_CHK = 1'b1;
`else
  localparam bit SEL_CHK = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_dbg;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  vec_t vecs[17];

  data_mem_responder_if #(.ADDR_W(10)) bus_if ();

  data_mem_responder #(
    .WAIT_CYCLES (W),
    .ADDR_W      (10)
  ) dut (
    .clk_dvid (clk),
    .reset    (rst),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drives one request, checks latency and the popped scoreboard entry.
  // With hold set, returns while the response is still being presented.
  task automatic run_txn(input vec_t v, input bit hold);
    exp_t e;
    int   k;
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = v.we;
    bus_if.req_addr  = v.addr;
    bus_if.req_sel   = v.sel;
    bus_if.req_wdata = v.wdata;
    k = 0;
    while (!bus_if.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", 32'(bus_if.req_ready), 32'd1);
    @(posedge clk);
    #1;
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    bus_if.req_valid = 1'b0;
    bus_if.req_we    = ~v.we;
    bus_if.req_addr  = ~v.addr;
    bus_if.req_sel   = ~v.sel;
    bus_if.req_wdata = $urandom;
    k = 1;
    while (!bus_if.rsp_valid && k <= 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency", 32'(k), 32'(W + 1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_rdata", bus_if.rsp_rdata, e.rdata);
      chk("rsp_err", 32'(bus_if.rsp_err), 32'(e.err));
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      chk("idle_after_rsp", 32'({bus_if.req_ready, bus_if.rsp_valid}), 32'b10);
    end
  endtask

  task automatic chk_dbg(input logic [3:0] a, input logic [31:0] exp, input string nm);
    bus_if.dbg_addr = a;
    #1;
    chk(nm, bus_if.dbg_data, exp);
  endtask

  initial begin
    vec_t v;
    logic seen;
    logic [31:0] held;

    vecs[0]  = '{1'b1, 10'd5,    4'b1111, 32'h12345678, 32'h0, 1'b0, 32'h12345678};
    vecs[1]  = '{1'b1, 10'd5,    4'b0010, 32'h0000AB00, 32'h0, 1'b0, 32'h1234AB78};
    vecs[2]  = '{1'b0, 10'd5,    4'b1111, 32'h0,        32'h1234AB78, 1'b0, 32'h1234AB78};
    vecs[3]  = '{1'b0, 10'd5,    4'b0100, 32'h0,        32'h00340000, 1'b0, 32'h1234AB78};
    vecs[4]  = '{1'b0, 10'd5,    4'b0000, 32'h0,        32'h0,        1'b0, 32'h1234AB78};
    vecs[5]  = '{1'b1, 10'd5,    4'b0000, 32'hFFFFFFFF, 32'h0,        1'b0, 32'h1234AB78};
    vecs[6]  = '{1'b0, 10'd5,    4'b1001, 32'h0,
                 SEL_CHK ? 32'h0 : 32'h12000078, SEL_CHK, 32'h1234AB78};
    vecs[7]  = '{1'b1, 10'd9,    4'b1111, 32'h00000000, 32'h0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 10'd9,    4'b0101, 32'hAABBCCDD, 32'h0, SEL_CHK,
                 SEL_CHK ? 32'h0 : 32'h00BB00DD};
    vecs[9]  = '{1'b0, 10'd9,    4'b1111, 32'h0,
                 SEL_CHK ? 32'h0 : 32'h00BB00DD, 1'b0, SEL_CHK ? 32'h0 : 32'h00BB00DD};
    vecs[10] = '{1'b0, 10'd9,    4'b0011, 32'h0,
                 SEL_CHK ? 32'h0 : 32'h000000DD, 1'b0, SEL_CHK ? 32'h0 : 32'h00BB00DD};
    vecs[11] = '{1'b1, 10'd7,    4'b1111, 32'h11223344, 32'h0, 1'b0, 32'h11223344};
    vecs[12] = '{1'b1, 10'd7,    4'b1100, 32'hAAAA0000, 32'h0, 1'b0, 32'hAAAA3344};
    vecs[13] = '{1'b0, 10'd7,    4'b1100, 32'h0,        32'hAAAA0000, 1'b0, 32'hAAAA3344};
    vecs[14] = '{1'b1, 10'd1023, 4'b1111, 32'h5A5AA5A5, 32'h0, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 10'd1023, 4'b1000, 32'h0,        32'h5A000000, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 10'd5,    4'b0001, 32'h0,        32'h00000078, 1'b0, 32'h1234AB78};

    bus_if.req_valid = 1'b0;
    bus_if.req_we    = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_sel   = '0;
    bus_if.req_wdata = '0;
    bus_if.rsp_ready = 1'b1;
    bus_if.dbg_addr  = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(bus_if.req_ready), 32'd1);
    chk("reset_rsp_rdata", bus_if.rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(bus_if.rsp_err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_txn(vecs[i], 1'b0);
      if (vecs[i].addr < 10'd16) chk_dbg(vecs[i].addr[3:0], vecs[i].exp_dbg, "dbg_data");
    end

    // Backpressure: response must hold while the request side is scrambled.
    bus_if.rsp_ready = 1'b0;
    v = '{1'b0, 10'd5, 4'b1111, 32'h0, 32'h1234AB78, 1'b0, 32'h0};
    run_txn(v, 1'b1);
    held = bus_if.rsp_rdata;
    for (int i = 0; i < 4; i++) begin
      bus_if.req_valid = 1'b1;
      bus_if.req_we    = 1'($urandom);
      bus_if.req_addr  = 10'($urandom);
      bus_if.req_sel   = 4'($urandom);
      bus_if.req_wdata = $urandom;
      @(posedge clk);
      #1;
      chk("hold_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
      chk("hold_rsp_rdata", bus_if.rsp_rdata, 32'h1234AB78);
      chk("hold_req_ready", 32'(bus_if.req_ready), 32'd0);
    end
    chk("hold_rdata_stable", bus_if.rsp_rdata, held);
    bus_if.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    chk("release_idle", 32'({bus_if.req_ready, bus_if.rsp_valid}), 32'b10);

    // Reset while waiting: pending write to word 7 must be dropped.
    @(negedge clk);
    bus_if.req_valid = 1'b1;
    bus_if.req_we    = 1'b1;
    bus_if.req_addr  = 10'd7;
    bus_if.req_sel   = 4'b1111;
    bus_if.req_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus_if.req_valid = 1'b0;
    chk("wait_req_ready", 32'(bus_if.req_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_wait_ready", 32'(bus_if.req_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus_if.rsp_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("rst_wait_no_rsp", 32'(seen), 32'd0);
    chk_dbg(4'd7, 32'hAAAA3344, "rst_wait_word7");

    // Reset while responding: the committed write must survive.
    bus_if.rsp_ready = 1'b0;
    v = '{1'b1, 10'd6, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0, 32'h0};
    run_txn(v, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.rsp_ready = 1'b1;
    chk("rst_resp_idle", 32'({bus_if.req_ready, bus_if.rsp_valid}), 32'b10);
    chk_dbg(4'd6, 32'hCAFEF00D, "rst_resp_word6");
    v = '{1'b0, 10'd6, 4'b0011, 32'h0, 32'h0000F00D, 1'b0, 32'h0};
    run_txn(v, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The module SHALL expose parameter WAIT_CYCLES, default 2, meaning idle cycles between request accept and response (0..15).
REQ-002 The module SHALL expose parameter ADDR_W, default 10, meaning word-address width (2^ADDR_W x 32-bit words).
REQ-003 clk_dvid  in  1  clock; all state changes on rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  initiator presents a request.
REQ-006 req_ready  out  1  responder can accept a request.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  ADDR_W  word address.
REQ-009 req_sel  in  4  byte-lane enables; bit n selects bits [8n+7:8n].
REQ-010 req_wdata  in  32  write data.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  initiator takes the response.
REQ-013 rsp_rdata  out  32  read data.
REQ-014 rsp_err  out  1  request rejected (see Configuration).
REQ-015 dbg_addr  in  4  debug word address for the display path (words 0-15).
REQ-016 dbg_data  out  32  debug word, combinational read of word dbg_addr.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; we/addr/sel/wdata SHALL be latched on that edge and later input changes ignored.
REQ-019 On accept, the FSM SHALL go to WAIT with counter loaded to WAIT_CYCLES, or directly to RESP when WAIT_CYCLES=0.
REQ-020 In WAIT the counter SHALL decrement each cycle; on the edge where it reaches 0 the FSM SHALL enter RESP.
REQ-021 A write SHALL commit only the selected byte lanes, on the edge entering RESP; unselected lanes keep old contents.
REQ-022 A read SHALL capture the stored word on the edge entering RESP; rsp_rdata SHALL carry selected lanes in place and zero in unselected lanes.
REQ-023 Writes SHALL return rsp_rdata = 0.
REQ-024 rsp_valid SHALL be 1 throughout RESP; rsp_rdata/rsp_err SHALL stay stable until rsp_valid && rsp_ready.
REQ-025 On rsp_valid && rsp_ready the FSM SHALL return to IDLE; a new request SHALL not be accepted in that same cycle (minimum spacing WAIT_CYCLES+2 cycles).
REQ-026 Request-to-response latency SHALL be WAIT_CYCLES+1 cycles from the accept edge to rsp_valid high.
REQ-027 req_sel=0000 SHALL complete normally with no storage change and rsp_rdata = 0.
REQ-028 Address SHALL use ADDR_W bits only; no wrap or bounds logic beyond truncation.
REQ-029 dbg_data SHALL reflect committed storage, including a write committed on the previous edge.

Reset
REQ-030 On reset the FSM SHALL enter IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 in the following cycle.
REQ-031 Reset in IDLE/WAIT SHALL discard the pending request; a pending write SHALL not commit.
REQ-032 Reset in RESP SHALL drop the response; an already-committed write SHALL persist.
REQ-033 Reset SHALL not clear storage contents.

Configuration
REQ-034 Macro DMEM_SEL_CHECK_EN defined: req_sel not in {0000,0001,0010,0100,1000,0011,1100,1111} SHALL yield rsp_err=1, no storage change, rsp_rdata=0, same latency.
REQ-035 Macro DMEM_SEL_CHECK_EN undefined: rsp_err SHALL be tied 0 and every sel pattern honored per REQ-021/022.

Structure
REQ-036 Package dmem_pkg SHALL hold the FSM state type, the legal-sel constant list, and the WAIT_CYCLES default.
REQ-037 Storage SHALL be a sub-module dmem_array (byte-lane write port plus one synchronous read and one combinational debug read).

Verification
REQ-038 Reset, then write addr 5, sel 1111, wdata 0x12345678, WAIT_CYCLES=2 -> rsp_valid high 3 cycles after accept, rsp_rdata 0; dbg_addr 5 -> 0x12345678.
REQ-039 Write addr 5 sel 0010 wdata 0x0000AB00, then read addr 5 sel 1111 -> rsp_rdata 0x1234AB78.
REQ-040 Read addr 5 sel 0100 -> rsp_rdata 0x00340000.
REQ-041 Hold rsp_ready=0 for 4 cycles, change req_* inputs meanwhile -> rsp_valid and rsp_rdata stable, req_ready 0; release -> IDLE next cycle.
REQ-042 Accept write addr 7 wdata 0xFFFFFFFF, assert reset in WAIT -> word 7 unchanged, rsp_valid never asserts, req_ready 1 next cycle.
REQ-043 With DMEM_SEL_CHECK_EN, write sel 0101 -> rsp_err 1, storage unchanged; without it -> lanes 0 and 2 written, rsp_err 0.
